// File: rtl/ps2_pkg.sv
// Shared PS/2 frame definitions: receiver states, frame bit values and the parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // True when the data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Multi-flop synchronizer followed by a level filter that only follows the input
// after FILTER_LEN consecutive samples disagree with the current filtered value.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic line_o
);
    localparam int CW = $clog2(FILTER_LEN) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q;
    logic [CW-1:0]          cnt_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign line_o   = filt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= line_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else if (sync_out != filt_q) begin
            // The disagreeing sample that completes the run flips the output.
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= sync_out;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: 11-bit frames sampled on filtered ps2_clk
// falling edges, single-byte holding register with valid/ready and error pulses.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       overrun
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_filt, dat_sync, clk_prev_q, sample_evt, tmo_hit;

    ps2_state_e     state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           par_err_q, par_err_d;
    logic           frm_err_q, frm_err_d;
    logic           tmo_err_q, tmo_err_d;
    logic           ovr_q, ovr_d;
    logic           frame_ok;

    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk(clk), .reset(reset), .line_i(ps2_clk), .line_o(clk_filt)
    );

    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(1)) u_dat_sync (
        .clk(clk), .reset(reset), .line_i(ps2_dat), .line_o(dat_sync)
    );

    assign sample_evt = clk_prev_q & ~clk_filt;
    // A sample landing on the expiry cycle keeps the frame alive.
    assign tmo_hit    = (state_q != ST_IDLE) && !sample_evt && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            clk_prev_q <= clk_filt;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            tmo_err_q  <= tmo_err_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = (state_q == ST_IDLE || sample_evt) ? '0 : tmo_q + TW'(1);
        if (tmo_hit) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
        end else if (sample_evt) begin
            case (state_q)
                ST_IDLE: begin
                    if (dat_sync == START_BIT) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d = {dat_sync, shift_q[7:1]};
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    parity_d = dat_sync;
                    state_d  = ST_STOP;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        frm_err_d = sample_evt && (((state_q == ST_IDLE) && (dat_sync != START_BIT)) ||
                                   ((state_q == ST_STOP) && (dat_sync != STOP_BIT)));
        frame_ok  = sample_evt && (state_q == ST_STOP) && (dat_sync == STOP_BIT) &&
                    odd_parity_ok(shift_q, parity_q);
        par_err_d = sample_evt && (state_q == ST_STOP) && (dat_sync == STOP_BIT) &&
                    !odd_parity_ok(shift_q, parity_q);
        tmo_err_d = tmo_hit;
        ovr_d     = frame_ok && valid_q && !ready;
        data_d    = data_q;
        valid_d   = valid_q && !ready;
        if (frame_ok && (!valid_q || ready)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign parity_err  = par_err_q;
    assign frame_err   = frm_err_q;
    assign timeout_err = tmo_err_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: directed scenarios plus random frames, with a
// frame-level reference model feeding expected-byte and expected-error queues.
module tb_ps2_frame_rx;
    localparam int TMO  = 500;
    localparam int HALF = 20;
    localparam int K_PAR = 1, K_FRM = 2, K_TMO = 3, K_OVR = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, parity_err, frame_err, timeout_err, overrun;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] dq[$];
    int         eq[$];
    bit         model_full = 1'b0;

    ps2_frame_rx #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .data(data), .valid(valid), .ready(ready), .parity_err(parity_err),
        .frame_err(frame_err), .timeout_err(timeout_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_eq(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end else begin
            $display("check %s = %0d ok", nm, got);
        end
    endtask

    // Reference outcome of one complete frame as the receiver's contract defines it.
    task automatic model_frame(input logic [7:0] d, input bit par, input bit stop);
        if (!stop) eq.push_back(K_FRM);
        else if ((($countones(d) + int'(par)) % 2) != 1) eq.push_back(K_PAR);
        else if (model_full) eq.push_back(K_OVR);
        else begin
            dq.push_back(d);
            if (!ready) model_full = 1'b1;
        end
    endtask

    function automatic bit good_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic send_bit(input logic b);
        ps2_dat = b;
        idle(HALF);
        ps2_clk = 1'b0;
        idle(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit stop, input int nbits);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        ps2_dat = 1'b1;
        idle(HALF);
    endtask

    task automatic full_frame(input logic [7:0] d, input bit par, input bit stop);
        model_frame(d, par, stop);
        send_frame(d, par, stop, 11);
    endtask

    task automatic chk_pulse(input logic sig, input int kind, input string nm);
        int exp_k;
        if (sig === 1'b1) begin
            vectors++;
            if (eq.size() == 0) begin
                miscompares++;
                $display("FAIL %s: got pulse, expected no error pulse", nm);
            end else begin
                exp_k = eq.pop_front();
                if (exp_k != kind) begin
                    miscompares++;
                    $display("FAIL %s: got error kind %0d, expected kind %0d", nm, kind, exp_k);
                end else begin
                    $display("pulse %s as expected", nm);
                end
            end
        end
    endtask

    // Monitor: compares every handshake and every error pulse against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid && ready) begin
                vectors++;
                if (dq.size() == 0) begin
                    miscompares++;
                    $display("FAIL byte: got 0x%02h, expected no byte", data);
                end else begin
                    logic [7:0] e;
                    e = dq.pop_front();
                    if (data !== e) begin
                        miscompares++;
                        $display("FAIL byte: got 0x%02h, expected 0x%02h", data, e);
                    end else begin
                        $display("byte 0x%02h received", data);
                    end
                end
            end
            chk_pulse(parity_err, K_PAR, "parity_err");
            chk_pulse(frame_err, K_FRM, "frame_err");
            chk_pulse(timeout_err, K_TMO, "timeout_err");
            chk_pulse(overrun, K_OVR, "overrun");
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got no finish, expected finish within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int r;
        idle(4);
        check_eq("reset data", int'(data), 0);
        check_eq("reset valid", int'(valid), 0);
        check_eq("reset parity_err", int'(parity_err), 0);
        check_eq("reset frame_err", int'(frame_err), 0);
        check_eq("reset timeout_err", int'(timeout_err), 0);
        check_eq("reset overrun", int'(overrun), 0);
        reset = 1'b0;
        idle(10);

        full_frame(8'hA5, 1'b1, 1'b1);
        full_frame(8'h3C, 1'b0, 1'b1);
        full_frame(8'h01, 1'b0, 1'b1);
        full_frame(8'h55, 1'b1, 1'b0);
        eq.push_back(K_FRM);
        send_bit(1'b1);
        idle(HALF);

        ready = 1'b0;
        full_frame(8'h11, 1'b1, 1'b1);
        full_frame(8'h22, 1'b1, 1'b1);
        idle(10);
        check_eq("held valid", int'(valid), 1);
        check_eq("held data", int'(data), 8'h11);
        ready = 1'b1;
        model_full = 1'b0;
        idle(10);
        check_eq("valid after drain", int'(valid), 0);

        eq.push_back(K_TMO);
        send_frame(8'h80, 1'b0, 1'b1, 5);
        idle(TMO + 200);
        full_frame(8'h80, 1'b0, 1'b1);

        ps2_clk = 1'b0;
        idle(3);
        ps2_clk = 1'b1;
        idle(40);

        send_frame(8'hFF, 1'b1, 1'b1, 5);
        reset = 1'b1;
        idle(5);
        reset = 1'b0;
        idle(10);
        full_frame(8'hFF, 1'b1, 1'b1);

        for (int i = 0; i < 25; i++) begin
            d = 8'($urandom);
            r = int'($urandom_range(0, 7));
            full_frame(d, good_par(d) ^ (r == 0), (r != 1));
            idle(int'($urandom_range(0, 50)));
        end

        idle(50);
        check_eq("bytes left unmatched", dq.size(), 0);
        check_eq("errors left unmatched", eq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
